// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite slave write path.
// Response codes, FSM states and the debug view exposed by the slave.
package axi_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam int AXI_PROT_W = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   aw_full;
        logic   w_full;
    } dbg_t;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry payload holding register with a full flag.
// Loads on valid && ready; the owner clears the flag once the payload is consumed.
module axi_lite_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    assign load = valid_i && ready_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = data_i;
        end
        // Clear and load never coincide: ready is low while the owner consumes.
        if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite slave write path: collects one AW and one W beat, issues a single
// register-bank write strobe, then returns OKAY or SLVERR on the B channel.
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = AXI_DATA_W,
    parameter int NUM_REGS      = 16,
    parameter bit PRIV_REQUIRED = 1'b0,
    localparam int IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [AXI_PROT_W-1:0] AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [AXI_STRB_W-1:0] WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  reg_wr_en,
    output logic [IDX_W-1:0]      reg_wr_idx,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [AXI_STRB_W-1:0] reg_wr_strb,
    output dbg_t                  dbg_o
);

    localparam int AW_W   = ADDR_WIDTH + AXI_PROT_W;
    localparam int W_W    = DATA_WIDTH + AXI_STRB_W;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

    state_t                state_q, state_d;
    logic                  out_en_q;
    logic                  aw_full, w_full;
    logic                  aw_hs, w_hs, b_hs;
    logic [AW_W-1:0]       aw_payload;
    logic [W_W-1:0]        w_payload;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_PROT_W-1:0] aw_prot;
    logic [DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic [WORD_W-1:0]     word;
    logic                  err;
    logic                  unused_aw_bits;

    // Handshakes: a beat transfers on a rising edge where VALID && READY.
    // READY is decoded purely from flops (state, full flags, out_en_q), so
    // there is never a combinational path from any VALID to any READY.
    // out_en_q keeps both READYs low while reset is asserted and for the
    // first cycle after its release.
    assign AWREADY = out_en_q && (state_q == IDLE) && !aw_full;
    assign WREADY  = out_en_q && (state_q == IDLE) && !w_full;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;

    axi_lite_hold_reg #(.WIDTH(AW_W)) u_aw_hold (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .valid_i (AWVALID),
        .ready_i (AWREADY),
        .clear_i (b_hs),
        .data_i  ({AWADDR, AWPROT}),
        .full_o  (aw_full),
        .data_o  (aw_payload)
    );

    axi_lite_hold_reg #(.WIDTH(W_W)) u_w_hold (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .valid_i (WVALID),
        .ready_i (WREADY),
        .clear_i (b_hs),
        .data_i  ({WDATA, WSTRB}),
        .full_o  (w_full),
        .data_o  (w_payload)
    );

    assign {aw_addr, aw_prot} = aw_payload;
    assign {w_data, w_strb}   = w_payload;

    // Byte offset bits and the non-privilege PROT bits carry no meaning here.
    assign unused_aw_bits = ^{aw_addr[1:0], aw_prot[2:1]};

    assign word = aw_addr[ADDR_WIDTH-1:2];
    assign err  = (word >= NUM_REGS_W) || (PRIV_REQUIRED && !aw_prot[0]);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        BVALID      = 1'b0;
        BRESP       = RESP_OKAY;
        reg_wr_en   = 1'b0;
        reg_wr_idx  = '0;
        reg_wr_data = '0;
        reg_wr_strb = '0;
        unique case (state_q)
            IDLE: begin
                // A beat landing on this edge counts as captured.
                if ((aw_full || aw_hs) && (w_full || w_hs)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                reg_wr_en   = !err;
                reg_wr_idx  = word[IDX_W-1:0];
                reg_wr_data = w_data;
                reg_wr_strb = w_strb;
                state_d     = RESP;
            end
            RESP: begin
                BVALID = 1'b1;
                BRESP  = resp_code(err);
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_o = '{state: state_q, aw_full: aw_full, w_full: w_full};

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Bench for axi_lite_write_slave: two instances (PRIV_REQUIRED 0 and 1) share
// all inputs; each transaction is predicted from address/prot arithmetic.
module tb_axi_lite_write_slave;
    import axi_lite_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        BREADY;

    logic        awready[2];
    logic        wready[2];
    logic [1:0]  bresp[2];
    logic        bvalid[2];
    logic        wr_en[2];
    logic [3:0]  wr_idx[2];
    logic [31:0] wr_data[2];
    logic [3:0]  wr_strb[2];
    dbg_t        dbg[2];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;     // <0: BREADY high throughout
        bit          hold_next; // present the next queued write during WRITE/RESP
    } txn_t;

    txn_t        txn_q[$];
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_write_slave #(.PRIV_REQUIRED(1'b0)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(awready[0]),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(wready[0]),
        .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(BREADY),
        .reg_wr_en(wr_en[0]), .reg_wr_idx(wr_idx[0]), .reg_wr_data(wr_data[0]),
        .reg_wr_strb(wr_strb[0]), .dbg_o(dbg[0])
    );

    axi_lite_write_slave #(.PRIV_REQUIRED(1'b1)) u_dut_priv (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(awready[1]),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(wready[1]),
        .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(BREADY),
        .reg_wr_en(wr_en[1]), .reg_wr_idx(wr_idx[1]), .reg_wr_data(wr_data[1]),
        .reg_wr_strb(wr_strb[1]), .dbg_o(dbg[1])
    );

    // Reference model: the register file has 16 words; word index = addr / 4.
    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] prot, input bit priv);
        int unsigned word;
        word = addr / 4;
        return (word >= 16) || (priv && (prot % 2 == 0));
    endfunction

    function automatic logic [39:0] model_write(input txn_t t);
        logic [3:0] idx;
        idx = 4'((t.addr / 4) % 16);
        return {idx, t.data, t.strb};
    endfunction

    task automatic apply_reset();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        #2 ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        exp_q.delete();
    endtask

    // Runs the queue head cycle by cycle; entered and left just after a rising edge.
    task automatic run_one();
        txn_t        t, nx;
        bit          have_nx, aw_done, w_done, b_done;
        bit          err[2];
        int          hs;
        logic [39:0] exp_w;
        logic [39:0] got_w;
        bit          exp_b;
        t = txn_q.pop_front();
        have_nx = t.hold_next && (txn_q.size() > 0);
        if (have_nx) nx = txn_q[0];
        err[0] = model_err(t.addr, t.prot, 1'b0);
        err[1] = model_err(t.addr, t.prot, 1'b1);
        aw_done = 0; w_done = 0; b_done = 0; hs = -1; exp_w = '0;
        for (int cyc = 0; cyc < 40 && !b_done; cyc++) begin
            if (hs < 0) begin
                AWVALID = !aw_done && (cyc >= t.aw_dly);
                WVALID  = !w_done && (cyc >= t.w_dly);
                AWADDR  = AWVALID ? t.addr : $urandom;
                AWPROT  = AWVALID ? t.prot : 3'($urandom);
                WDATA   = WVALID ? t.data : $urandom;
                WSTRB   = WVALID ? t.strb : 4'($urandom);
            end else begin
                AWVALID = have_nx;
                WVALID  = have_nx;
                AWADDR  = have_nx ? nx.addr : $urandom;
                AWPROT  = have_nx ? nx.prot : 3'($urandom);
                WDATA   = have_nx ? nx.data : $urandom;
                WSTRB   = have_nx ? nx.strb : 4'($urandom);
            end
            BREADY = (t.b_dly < 0) || (hs >= 0 && cyc >= hs + 2 + t.b_dly);
            @(negedge ACLK);
            if (hs >= 0 && cyc == hs + 1) exp_w = exp_q.pop_front();
            exp_b = (hs >= 0) && (cyc >= hs + 2);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (awready[d] !== ((hs < 0) && !aw_done))
                    $display("FAIL awready dut%0d cyc%0d addr=%h: got %b want %b", d, cyc, t.addr, awready[d], (hs < 0) && !aw_done);
                else n_pass++;
                n_checks++;
                if (wready[d] !== ((hs < 0) && !w_done))
                    $display("FAIL wready dut%0d cyc%0d addr=%h: got %b want %b", d, cyc, t.addr, wready[d], (hs < 0) && !w_done);
                else n_pass++;
                n_checks++;
                if (wr_en[d] !== (hs >= 0 && cyc == hs + 1 && !err[d]))
                    $display("FAIL reg_wr_en dut%0d cyc%0d addr=%h prot=%b: got %b want %b", d, cyc, t.addr, t.prot, wr_en[d], (hs >= 0 && cyc == hs + 1 && !err[d]));
                else n_pass++;
                n_checks++;
                if (bvalid[d] !== exp_b)
                    $display("FAIL bvalid dut%0d cyc%0d addr=%h: got %b want %b", d, cyc, t.addr, bvalid[d], exp_b);
                else n_pass++;
                if (exp_b) begin
                    n_checks++;
                    if (bresp[d] !== (err[d] ? 2'b10 : 2'b00))
                        $display("FAIL bresp dut%0d cyc%0d addr=%h prot=%b: got %b want %b", d, cyc, t.addr, t.prot, bresp[d], (err[d] ? 2'b10 : 2'b00));
                    else n_pass++;
                end
                if (hs >= 0 && cyc == hs + 1) begin
                    got_w = {wr_idx[d], wr_data[d], wr_strb[d]};
                    n_checks++;
                    if (got_w !== exp_w)
                        $display("FAIL reg_wr_payload dut%0d addr=%h: got idx/data/strb %h want %h", d, t.addr, got_w, exp_w);
                    else n_pass++;
                end
            end
            if (hs < 0) begin
                if (AWVALID) aw_done = 1;
                if (WVALID)  w_done = 1;
                if (aw_done && w_done) begin
                    hs = cyc;
                    exp_q.push_back(model_write(t));
                end
            end else if (exp_b && BREADY) begin
                b_done = 1;
            end
            @(posedge ACLK); #1;
        end
        if (!b_done) begin
            n_checks++;
            $display("FAIL txn_timeout addr=%h: got no B handshake want one within 40 cycles", t.addr);
            txn_q.delete();
            apply_reset();
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({awready[d], wready[d], bvalid[d], bresp[d], wr_en[d], wr_idx[d], wr_data[d], wr_strb[d]} !== '0)
                $display("FAIL reset_outputs dut%0d: got ar=%b wr=%b bv=%b br=%b en=%b idx=%h data=%h strb=%h want all zero",
                         d, awready[d], wready[d], bvalid[d], bresp[d], wr_en[d], wr_idx[d], wr_data[d], wr_strb[d]);
            else n_pass++;
            n_checks++;
            if (dbg[d] !== '{state: IDLE, aw_full: 1'b0, w_full: 1'b0})
                $display("FAIL reset_state dut%0d: got %h want IDLE with flags clear", d, dbg[d]);
            else n_pass++;
        end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic test_same_cycle();
        txn_q.push_back('{32'h0000_0008, 3'b000, 32'hDEAD_BEEF, 4'hF, 0, 0, -1, 1'b0});
        run_one();
    endtask

    task automatic test_aw_first();
        txn_q.push_back('{32'h0000_0004, 3'b000, 32'h1234_5678, 4'h3, 0, 3, -1, 1'b0});
        run_one();
    endtask

    task automatic test_w_first_and_decode();
        txn_q.push_back('{32'h0000_003C, 3'b001, 32'hCAFE_0001, 4'hA, 2, 0, 0, 1'b0});
        txn_q.push_back('{32'h0000_0040, 3'b001, 32'hCAFE_0002, 4'h5, 2, 0, 0, 1'b0});
        txn_q.push_back('{32'h0000_0023, 3'b001, 32'hCAFE_0003, 4'h0, 1, 1, 1, 1'b0});
        repeat (3) run_one();
    endtask

    task automatic test_prot();
        txn_q.push_back('{32'hFFFF_FFFF, 3'b000, 32'h0BAD_F00D, 4'hF, 0, 1, -1, 1'b0});
        txn_q.push_back('{32'h0000_0000, 3'b000, 32'h1111_2222, 4'hF, 0, 0, -1, 1'b0});
        txn_q.push_back('{32'h0000_0000, 3'b001, 32'h3333_4444, 4'hF, 0, 0, -1, 1'b0});
        repeat (3) run_one();
    endtask

    task automatic test_back_to_back();
        txn_q.push_back('{32'h0000_0018, 3'b001, 32'hA5A5_0001, 4'hC, 0, 0, 4, 1'b1});
        txn_q.push_back('{32'h0000_001C, 3'b001, 32'h5A5A_0002, 4'h9, 0, 0, 0, 1'b1});
        txn_q.push_back('{32'h0000_0100, 3'b000, 32'h5A5A_0003, 4'h1, 0, 0, 2, 1'b0});
        repeat (3) run_one();
    endtask

    task automatic test_reset_mid();
        AWADDR = 32'h10; AWPROT = 3'b001; AWVALID = 1'b1;
        WDATA = $urandom; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        n_checks++;
        if (bvalid[0] !== 1'b1) $display("FAIL resp_before_reset: got bvalid %b want 1", bvalid[0]);
        else n_pass++;
        #2 ARESETn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({bvalid[d], wr_en[d]} !== 2'b00 || dbg[d].state !== IDLE)
                $display("FAIL async_reset_resp dut%0d: got bvalid=%b en=%b state=%h want 0 0 IDLE", d, bvalid[d], wr_en[d], dbg[d].state);
            else n_pass++;
        end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        AWADDR = 32'h14; AWPROT = 3'b001; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (dbg[0].aw_full !== 1'b1 || awready[0] !== 1'b0 || wready[0] !== 1'b1)
            $display("FAIL aw_only_capture: got full=%b ar=%b wr=%b want 1 0 1", dbg[0].aw_full, awready[0], wready[0]);
        else n_pass++;
        #2 ARESETn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dbg[d].aw_full !== 1'b0 || dbg[d].w_full !== 1'b0 || bvalid[d] !== 1'b0)
                $display("FAIL async_reset_idle dut%0d: got aw_full=%b w_full=%b bvalid=%b want 0 0 0", d, dbg[d].aw_full, dbg[d].w_full, bvalid[d]);
            else n_pass++;
        end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        WDATA = $urandom; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (wr_en[d] !== 1'b0 || bvalid[d] !== 1'b0 || awready[d] !== 1'b1 || dbg[d].w_full !== 1'b1)
                    $display("FAIL w_alone_after_reset dut%0d cyc%0d: got en=%b bv=%b ar=%b w_full=%b want 0 0 1 1",
                             d, c, wr_en[d], bvalid[d], awready[d], dbg[d].w_full);
                else n_pass++;
            end
            @(posedge ACLK); #1;
        end
        apply_reset();
    endtask

    task automatic test_random();
        txn_t t;
        bit   prev_hold;
        prev_hold = 0;
        for (int i = 0; i < 30; i++) begin
            t.addr = ($urandom_range(0, 3) == 0) ? $urandom : ((32'($urandom_range(0, 23)) << 2) | 32'($urandom_range(0, 3)));
            t.prot = 3'($urandom_range(0, 7));
            t.data = $urandom;
            t.strb = 4'($urandom_range(0, 15));
            t.aw_dly = prev_hold ? 0 : $urandom_range(0, 3);
            t.w_dly  = prev_hold ? 0 : $urandom_range(0, 3);
            t.b_dly  = $urandom_range(0, 4) - 1;
            t.hold_next = ($urandom_range(0, 3) == 0);
            prev_hold = t.hold_next;
            txn_q.push_back(t);
        end
        while (txn_q.size() > 0) run_one();
    endtask

    initial begin
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        test_reset();
        test_same_cycle();
        test_aw_first();
        test_w_first_and_decode();
        test_prot();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
